param_ram: RTL and testbench
============================

# param_ram

Parametrised single-port synchronous RAM, the successor of the team's fixed 16x8 RAM. Adds configurable width and depth, per-byte write enables, a selectable read-during-write mode, a valid/ready access handshake, out-of-range address detection, and a hardware clear sequencer. The sequencer zero-fills the array after reset and on request. It sits as the general-purpose scratch and buffer memory next to the ALU datapath.

## Interface
- DATA_W, 8, word width in bits; must be a multiple of 8.
- ADDR_W, 4, address width.
- DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, read-during-write result: 0 = read-first (old word), 1 = write-first (merged new word).
- CLEAR_VAL, 0, value written to every word by the clear sequence; DATA_W bits.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; bit i covers din[8i+7:8i]; ignored on reads.
- ready  out  1  access accepted this cycle when req && ready.
- dout  out  DATA_W  read data; holds its value between accesses.
- dout_valid  out  1  one-cycle pulse; dout is valid this cycle.
- dout_err  out  1  qualifies dout_valid; 1 = the access addressed >= DEPTH.
- clr_start  in  1  request a full clear; honoured only in IDLE.
- busy  out  1  clear sequence in progress; equals !ready.

## Operation
- FSM states: CLEAR, IDLE.
- While rst_n = 0: state = CLEAR, clear pointer = 0, dout = 0, dout_valid = 0, dout_err = 0, busy = 1, ready = 0.
- Array contents are not reset asynchronously; they are defined only by the clear sweep.
- CLEAR writes CLEAR_VAL to mem[ptr] each cycle, ptr = 0..DEPTH-1. After the write to DEPTH-1 the FSM goes to IDLE.
- In CLEAR, req is not accepted. The requester holds req, we, addr, din and be until it sees ready.
- IDLE: ready = 1. An accepted access (req && ready) is processed as follows.
  - Write, addr < DEPTH: every byte lane with be[i] = 1 is updated. Lanes with be[i] = 0 are unchanged. be = 0 is a legal no-op write.
  - Every accepted access, read or write, produces dout and dout_valid = 1 on the next cycle.
  - Write with RDW_MODE = 0: dout is the word before the write.
  - Write with RDW_MODE = 1: dout is the word after the byte merge.
  - addr >= DEPTH: the write is dropped, dout = 0 and dout_err = 1 with dout_valid.
- clr_start in IDLE: FSM goes to CLEAR next cycle with ptr = 0.
  - If req is also accepted in that cycle, the access completes normally, including its dout_valid. The clear then overwrites the array.
- clr_start in CLEAR is ignored; the sweep is not restarted.
- Reset asserted mid-clear or mid-access: the outputs take their reset values immediately. The sweep restarts from 0 when rst_n is released, and any in-flight dout_valid is lost.

## Timing
- Clear duration: exactly DEPTH cycles after rst_n is released, or after the cycle in which clr_start is accepted. ready rises on the cycle after the last clear write.
- Read and write latency: 1 cycle from the accepting edge to dout_valid. Throughput is one access per cycle in IDLE.
- dout changes only on cycles with dout_valid = 1.
- Back-to-back write then read of the same address returns the written data; there is no hazard, because the write completes at the accepting edge.

## Structure
- Package ram_pkg holds:
  - the state enum (ST_CLEAR, ST_IDLE);
  - the RDW_READ_FIRST and RDW_WRITE_FIRST constants;
  - a helper function for the byte-merge mask.
- Sub-module param_ram_clear_seq holds the FSM and the pointer. It outputs clr_we, clr_addr and busy.
- The top level muxes the sequencer and host write ports into the array, and owns the output registers.

## Test plan
- Reset with DATA_W=16, DEPTH=16 → busy = 1 for exactly 16 cycles after rst_n rises, then ready = 1. Reading every address returns 0x0000 with dout_err = 0.
- Write 0xBEEF to addr 3 with be = 2'b11, then write 0x12xx to addr 3 with be = 2'b10, then read addr 3 → 0x12EF, dout_valid one cycle after each accepted access.
- Write-mode check: the word at addr 5 holds 0x00AA; write 0x0055 to addr 5 → dout = 0x00AA with RDW_MODE = 0, and 0x0055 with RDW_MODE = 1.
- DEPTH=12, ADDR_W=4: write 0xFFFF to addr 13 → dout_err = 1 and dout = 0. A subsequent read of addr 13 gives dout_err = 1; addresses 0..11 are unchanged.
- clr_start together with an accepted write of 0x1234 to addr 0 → the write's dout_valid appears, busy = 1 for 16 cycles, then a read of addr 0 returns CLEAR_VAL. A clr_start pulse mid-sweep does not extend busy.
- Assert rst_n = 0 at sweep cycle 7 → outputs are at reset values while rst_n is low. The full 16-cycle sweep repeats after release; req held during CLEAR is accepted on the first ready cycle.

Source files
------------

// File: rtl/param_ram_pkg.sv
// Shared types and helpers for the parametrised scratch RAM.
// Holds the clear-sequencer state encoding, read-during-write modes and lane masking.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Expands one byte-enable bit into the 8-bit mask for its lane.
  function automatic logic [7:0] lane_mask(input logic en);
    return {8{en}};
  endfunction

endpackage

// File: rtl/param_ram_clear_seq.sv
// Clear sequencer: sweeps every word after reset or on request, then idles.
// busy is high for exactly DEPTH cycles per sweep.
import ram_pkg::*;

module param_ram_clear_seq #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_we   = 1'b0;
    clr_addr = ptr_q;
    busy     = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        busy   = 1'b1;
        // clr_start is deliberately ignored here so a sweep is never stretched.
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/param_ram.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write,
// valid/ready handshake, out-of-range detection and a hardware clear sweep.
import ram_pkg::*;

module param_ram #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 4,
  parameter int                DEPTH     = 16,
  parameter int                RDW_MODE  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                dout_err,
  input  logic                clr_start,
  output logic                busy
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              acc;
  logic              in_range;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  param_ram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .busy      (busy)
  );

  assign ready = !busy;
  assign acc   = req && ready;

  // A full power-of-two array cannot be over-addressed, so skip the compare.
  if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (32'(addr) < DEPTH);
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign mask[8*gi +: 8] = lane_mask(be[gi]);
  end

  assign old_word    = in_range ? mem[addr] : '0;
  assign merged_word = (old_word & ~mask) | (din & mask);

  // The sweep and host never collide: the host port is only live when not busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = merged_word;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = CLEAR_VAL;
    end else if (acc && we && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (acc) begin
      valid_d = 1'b1;
      if (!in_range) begin
        dout_d = '0;
        err_d  = 1'b1;
      end else if (we && (RDW_MODE == RDW_WRITE_FIRST)) begin
        dout_d = merged_word;
      end else begin
        dout_d = old_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_err   = err_q;

endmodule

// File: tb/tb_param_ram.sv
// Directed bench for param_ram: two 16x16 instances (read-first / write-first)
// sharing stimulus, plus a 12-deep instance for out-of-range handling.
module tb_param_ram;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req, we, clr_start;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [1:0]  be;
  logic        ready_a, valid_a, err_a, busy_a;
  logic        ready_b, valid_b, err_b, busy_b;
  logic [15:0] dout_a, dout_b;

  logic        req_c, we_c, clr_c;
  logic [3:0]  addr_c;
  logic [15:0] din_c;
  logic [1:0]  be_c;
  logic        ready_c, valid_c, err_c, busy_c;
  logic [15:0] dout_c;

  param_ram #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RDW_MODE(0), .CLEAR_VAL(16'h0000)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .din(din), .be(be),
    .ready(ready_a), .dout(dout_a), .dout_valid(valid_a), .dout_err(err_a),
    .clr_start(clr_start), .busy(busy_a));

  param_ram #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RDW_MODE(1), .CLEAR_VAL(16'h0000)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .din(din), .be(be),
    .ready(ready_b), .dout(dout_b), .dout_valid(valid_b), .dout_err(err_b),
    .clr_start(clr_start), .busy(busy_b));

  param_ram #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RDW_MODE(0), .CLEAR_VAL(16'h0000)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .we(we_c), .addr(addr_c), .din(din_c), .be(be_c),
    .ready(ready_c), .dout(dout_c), .dout_valid(valid_c), .dout_err(err_c),
    .clr_start(clr_c), .busy(busy_c));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [15:0] d;
    logic [1:0]  b;
    logic [15:0] ea;  // expected dout, read-first instance
    logic [15:0] eb;  // expected dout, write-first instance
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One accepted access; call at a negedge, returns at a negedge with req low.
  task automatic acc(input bit on_c, input logic w, input logic [3:0] a, input logic [15:0] d,
                     input logic [1:0] b, input logic [15:0] ea, input logic [15:0] eb,
                     input logic eerr, input string nm);
    int n;
    if (on_c) begin
      req_c = 1'b1; we_c = w; addr_c = a; din_c = d; be_c = b;
    end else begin
      req = 1'b1; we = w; addr = a; din = d; be = b;
    end
    n = 0;
    while (!(on_c ? ready_c : ready_a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({nm, "/ready_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    if (on_c) begin
      chk({nm, "/valid"}, valid_c, 1'b1);
      chk({nm, "/dout"}, dout_c, ea);
      chk({nm, "/err"}, err_c, eerr);
      req_c = 1'b0;
    end else begin
      chk({nm, "/valid"}, valid_a, 1'b1);
      chk({nm, "/dout_rf"}, dout_a, ea);
      chk({nm, "/dout_wf"}, dout_b, eb);
      chk({nm, "/err"}, err_a, 1'b0);
      req = 1'b0;
    end
    $display("txn %s we=%0d addr=%0d din=%h be=%b -> dout_rf=%h dout_wf=%h dout_c=%h err_c=%0d",
             nm, w, a, d, b, dout_a, dout_b, dout_c, err_c);
    @(negedge clk);
    chk({nm, "/pulse"}, on_c ? valid_c : valid_a, 1'b0);
    chk({nm, "/hold"}, on_c ? dout_c : dout_a, ea);
  endtask

  initial begin
    int cnt, cnt_c;
    req = 0; we = 0; addr = 0; din = 0; be = 0; clr_start = 0;
    req_c = 0; we_c = 0; addr_c = 0; din_c = 0; be_c = 0; clr_c = 0;
    rst_n = 1'b0;

    vecs[0]  = '{1'b1, 4'd3, 16'hBEEF, 2'b11, 16'h0000, 16'hBEEF};
    vecs[1]  = '{1'b1, 4'd3, 16'h1234, 2'b10, 16'hBEEF, 16'h12EF};
    vecs[2]  = '{1'b0, 4'd3, 16'h0000, 2'b00, 16'h12EF, 16'h12EF};
    vecs[3]  = '{1'b1, 4'd5, 16'h00AA, 2'b11, 16'h0000, 16'h00AA};
    vecs[4]  = '{1'b1, 4'd5, 16'h0055, 2'b11, 16'h00AA, 16'h0055};
    vecs[5]  = '{1'b0, 4'd5, 16'h0000, 2'b11, 16'h0055, 16'h0055};
    vecs[6]  = '{1'b1, 4'd7, 16'hABCD, 2'b00, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 4'd7, 16'h0000, 2'b00, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 4'd7, 16'hABCD, 2'b01, 16'h0000, 16'h00CD};
    vecs[9]  = '{1'b0, 4'd7, 16'hFFFF, 2'b11, 16'h00CD, 16'h00CD};
    vecs[10] = '{1'b0, 4'd15, 16'h0000, 2'b00, 16'h0000, 16'h0000};

    repeat (3) @(negedge clk);
    chk("rst/busy", busy_a, 1'b1);
    chk("rst/ready", ready_a, 1'b0);
    chk("rst/dout", dout_a, 16'h0000);
    chk("rst/valid", valid_a, 1'b0);
    chk("rst/err", err_a, 1'b0);

    // Release reset and measure the sweep length of both depths.
    rst_n = 1'b1;
    cnt = 0; cnt_c = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      if (busy_c) cnt_c++;
      @(negedge clk);
    end
    chk("sweep16/busy_cycles", cnt, 32'd16);
    chk("sweep12/busy_cycles", cnt_c, 32'd12);
    chk("sweep16/ready", ready_a, 1'b1);

    for (int i = 0; i < 16; i++) acc(0, 1'b0, 4'(i), 16'h0, 2'b00, 16'h0, 16'h0, 1'b0, "clr_read");

    for (int i = 0; i < 11; i++)
      acc(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, vecs[i].ea, vecs[i].eb, 1'b0, "vec");

    // Back-to-back write then read of the same address.
    req = 1; we = 1; addr = 4'd9; din = 16'h5A5A; be = 2'b11;
    @(negedge clk);
    chk("b2b_wr/valid", valid_a, 1'b1);
    chk("b2b_wr/dout_rf", dout_a, 16'h0000);
    chk("b2b_wr/dout_wf", dout_b, 16'h5A5A);
    we = 0;
    @(negedge clk);
    chk("b2b_rd/valid", valid_a, 1'b1);
    chk("b2b_rd/dout", dout_a, 16'h5A5A);
    req = 0;
    $display("txn b2b write/read addr 9 -> dout_rf=%h dout_wf=%h", dout_a, dout_b);
    @(negedge clk);

    // Out-of-range handling on the 12-deep instance.
    acc(1, 1'b1, 4'd11, 16'h1111, 2'b11, 16'h0000, 16'h0, 1'b0, "c_wr11");
    acc(1, 1'b1, 4'd0,  16'h2222, 2'b11, 16'h0000, 16'h0, 1'b0, "c_wr0");
    acc(1, 1'b1, 4'd13, 16'hFFFF, 2'b11, 16'h0000, 16'h0, 1'b1, "c_wr13");
    acc(1, 1'b0, 4'd13, 16'h0000, 2'b00, 16'h0000, 16'h0, 1'b1, "c_rd13");
    acc(1, 1'b0, 4'd11, 16'h0000, 2'b00, 16'h1111, 16'h0, 1'b0, "c_rd11");
    acc(1, 1'b0, 4'd0,  16'h0000, 2'b00, 16'h2222, 16'h0, 1'b0, "c_rd0");
    acc(1, 1'b0, 4'd1,  16'h0000, 2'b00, 16'h0000, 16'h0, 1'b0, "c_rd1");

    // clr_start together with an accepted write; mid-sweep clr_start ignored.
    req = 1; we = 1; addr = 4'd0; din = 16'h1234; be = 2'b11; clr_start = 1;
    @(negedge clk);
    chk("clrwr/valid", valid_a, 1'b1);
    chk("clrwr/dout_rf", dout_a, 16'h0000);
    chk("clrwr/dout_wf", dout_b, 16'h1234);
    chk("clrwr/busy", busy_a, 1'b1);
    $display("txn clr+write addr 0 -> dout_rf=%h dout_wf=%h", dout_a, dout_b);
    req = 0; clr_start = 0;
    cnt = 1;
    while (busy_a && cnt < 100) begin
      @(negedge clk);
      if (busy_a) cnt++;
      clr_start = (cnt == 5);
    end
    clr_start = 0;
    chk("clrwr/busy_cycles", cnt, 32'd16);
    acc(0, 1'b0, 4'd0, 16'h0, 2'b00, 16'h0000, 16'h0000, 1'b0, "post_clr_rd0");
    acc(0, 1'b0, 4'd3, 16'h0, 2'b00, 16'h0000, 16'h0000, 1'b0, "post_clr_rd3");

    // Reset asserted mid-sweep, with a read held pending across the clear.
    acc(0, 1'b1, 4'd2, 16'h7777, 2'b11, 16'h0000, 16'h7777, 1'b0, "pre_rst_wr2");
    acc(0, 1'b0, 4'd2, 16'h0000, 2'b00, 16'h7777, 16'h7777, 1'b0, "pre_rst_rd2");
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst/busy", busy_a, 1'b1);
    chk("midrst/ready", ready_a, 1'b0);
    chk("midrst/dout", dout_a, 16'h0000);
    chk("midrst/valid", valid_a, 1'b0);
    req = 1; we = 0; addr = 4'd2;
    @(negedge clk);
    chk("midrst/dout_hold", dout_b, 16'h0000);
    rst_n = 1'b1;
    cnt = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      if (valid_a) chk("midrst/no_valid_in_clear", valid_a, 1'b0);
      @(negedge clk);
    end
    chk("midrst/busy_cycles", cnt, 32'd16);
    @(negedge clk);
    chk("held_req/valid", valid_a, 1'b1);
    chk("held_req/dout", dout_a, 16'h0000);
    chk("held_req/err", err_a, 1'b0);
    $display("txn held read addr 2 after reset -> dout=%h valid=%0d", dout_a, valid_a);
    req = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
